// File: rtl/dvp_camera_emulator.sv
// rtl/dvp_camera_emulator.sv - DVP camera-side transmitter (frame buffer or colour-bar source)
module dvp_camera_emulator #(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int H_BLANK   = 64,
  parameter int VSYNC_LEN = 16,
  parameter int VBP_LINES = 2,
  parameter int VFP_LINES = 2,
  parameter int ADDR_W    = 17
) (
  input  logic              csi_pclk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              pattern_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rdaddr,
  input  logic [15:0]       rddata,
  output logic              csi_vsync,
  output logic              csi_hsync,
  output logic [7:0]        csi_data,
  output logic              frame_start,
  output logic              busy
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HS_LEN   = 2 * H_ACTIVE;
  localparam int COL_MAX  = (LINE_LEN > VSYNC_LEN) ? LINE_LEN : VSYNC_LEN;
  localparam int COL_W    = $clog2(COL_MAX + 1);
  localparam int LN_MAX0  = (V_ACTIVE > VBP_LINES) ? V_ACTIVE : VBP_LINES;
  localparam int LN_MAX   = (LN_MAX0 > VFP_LINES) ? LN_MAX0 : VFP_LINES;
  localparam int LN_W     = $clog2(LN_MAX + 1);

  localparam logic [COL_W-1:0] VS_END     = COL_W'(VSYNC_LEN - 1);
  localparam logic [COL_W-1:0] LINE_END   = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] FETCH0     = COL_W'(LINE_LEN - 2);
  localparam logic [COL_W-1:0] FETCH_LAST = COL_W'(HS_LEN - 4);
  localparam logic [COL_W-1:0] HS_END     = COL_W'(HS_LEN);
  localparam logic [COL_W-1:0] BAR_DIV    = COL_W'(H_ACTIVE / 8);
  localparam logic [LN_W-1:0]  VBP_LAST   = LN_W'(VBP_LINES - 1);
  localparam logic [LN_W-1:0]  ACT_LAST   = LN_W'(V_ACTIVE - 1);
  localparam logic [LN_W-1:0]  VFP_LAST   = LN_W'(VFP_LINES - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t           state, nstate;
  logic [COL_W-1:0] col, ncol;
  logic [LN_W-1:0]  line, nline, line_last;
  logic             pat_q, pat_d;
  logic [7:0]       lo_q;

  logic              enter_vsync, hsync_d, fetch_d, rd_en_d;
  logic [7:0]        data_d;
  logic [ADDR_W-1:0] rdaddr_d;
  logic [COL_W-1:0]  pix_x, bar;
  logic [15:0]       colour;

  always_comb begin
    nstate = state;
    ncol   = col;
    nline  = line;
    case (state)
      VBP:     line_last = VBP_LAST;
      ACTIVE:  line_last = ACT_LAST;
      default: line_last = VFP_LAST;
    endcase
    case (state)
      IDLE: begin
        if (enable) begin
          nstate = VSYNC;
          ncol   = '0;
          nline  = '0;
        end
      end
      VSYNC: begin
        if (col == VS_END) begin
          nstate = VBP;
          ncol   = '0;
        end else begin
          ncol = col + COL_W'(1);
        end
      end
      VBP, ACTIVE, VFP: begin
        if (col == LINE_END) begin
          ncol = '0;
          if (line == line_last) begin
            nline = '0;
            case (state)
              VBP:     nstate = ACTIVE;
              ACTIVE:  nstate = VFP;
              default: nstate = enable ? VSYNC : IDLE;
            endcase
          end else begin
            nline = line + LN_W'(1);
          end
        end else begin
          ncol = col + COL_W'(1);
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they line up with it once registered.
  always_comb begin
    enter_vsync = (nstate == VSYNC) && (state != VSYNC);
    pat_d       = enter_vsync ? pattern_sel : pat_q;
    hsync_d     = (nstate == ACTIVE) && (ncol < HS_END);
    // Pixel k is fetched two cycles ahead of its high byte; pixel 0 falls in the prior blank.
    fetch_d     = ((nstate == ACTIVE) && !ncol[0] && (ncol <= FETCH_LAST)) ||
                  ((ncol == FETCH0) &&
                   (((nstate == VBP) && (nline == VBP_LAST)) ||
                    ((nstate == ACTIVE) && (nline != ACT_LAST))));
    rd_en_d     = fetch_d && !pat_d;
    if (enter_vsync) begin
      rdaddr_d = '0;
    end else if (rd_en) begin
      rdaddr_d = rdaddr + ADDR_W'(1);
    end else begin
      rdaddr_d = rdaddr;
    end
    pix_x = ncol >> 1;
    bar   = pix_x / BAR_DIV;
    case (bar)
      COL_W'(0): colour = 16'hFFFF;
      COL_W'(1): colour = 16'hFFE0;
      COL_W'(2): colour = 16'h07FF;
      COL_W'(3): colour = 16'h07E0;
      COL_W'(4): colour = 16'hF81F;
      COL_W'(5): colour = 16'hF800;
      COL_W'(6): colour = 16'h001F;
      default:   colour = 16'h0000;
    endcase
    if (!hsync_d) begin
      data_d = 8'h00;
    end else if (pat_d) begin
      data_d = ncol[0] ? colour[7:0] : colour[15:8];
    end else begin
      data_d = ncol[0] ? lo_q : rddata[15:8];
    end
  end

  always_ff @(posedge csi_pclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      col         <= '0;
      line        <= '0;
      pat_q       <= 1'b0;
      lo_q        <= 8'h00;
      rd_en       <= 1'b0;
      rdaddr      <= '0;
      csi_vsync   <= 1'b0;
      csi_hsync   <= 1'b0;
      csi_data    <= 8'h00;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= nstate;
      col         <= ncol;
      line        <= nline;
      pat_q       <= pat_d;
      if (hsync_d && !ncol[0]) begin
        lo_q <= rddata[7:0];
      end
      rd_en       <= rd_en_d;
      rdaddr      <= rdaddr_d;
      csi_vsync   <= (nstate == VSYNC);
      csi_hsync   <= hsync_d;
      csi_data    <= data_d;
      frame_start <= enter_vsync;
      busy        <= (nstate != IDLE);
    end
  end

endmodule

// File: tb/tb_dvp_camera_emulator.sv
// tb/tb_dvp_camera_emulator.sv - scoreboard bench for dvp_camera_emulator
module tb_dvp_camera_emulator;

  localparam int AW    = 17;
  localparam int FRAME = 83;

  logic          csi_pclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          pattern_sel = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rdaddr;
  logic [15:0]   rddata = 16'h0000;
  logic          csi_vsync, csi_hsync, frame_start, busy;
  logic [7:0]    csi_data;

  dvp_camera_emulator #(
    .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(4), .VSYNC_LEN(3),
    .VBP_LINES(1), .VFP_LINES(1), .ADDR_W(AW)
  ) dut (
    .csi_pclk(csi_pclk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .rd_en(rd_en), .rdaddr(rdaddr), .rddata(rddata), .csi_vsync(csi_vsync),
    .csi_hsync(csi_hsync), .csi_data(csi_data), .frame_start(frame_start), .busy(busy)
  );

  always #5 csi_pclk = ~csi_pclk;

  // Frame-buffer model: returns the address as data, one cycle after rd_en.
  always_ff @(posedge csi_pclk) begin
    if (rd_en) rddata <= 16'(rdaddr);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_bytes[$];
  int exp_addr[$];
  int rd_cyc[$];
  int fs_cyc[$];
  int vs_len_q[$];
  int vs_fall_q[$];
  int hs_rise_q[$];
  bit mon_on = 1'b1;
  int rd_cnt = 0;

  logic [7:0] pat_bytes[16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_pattern_frame();
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 16; b++) exp_bytes.push_back(pat_bytes[b]);
  endtask

  task automatic push_fb_frame();
    for (int a = 0; a < 16; a++) begin
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(8'(a));
      exp_addr.push_back(a);
    end
  endtask

  task automatic wait_fs(input int n, input int budget);
    int k;
    k = 0;
    while (fs_cyc.size() < n && k < budget) begin
      @(negedge csi_pclk);
      k++;
    end
    if (fs_cyc.size() < n) fail("frame_start_timeout");
  endtask

  task automatic wait_hsync();
    int k;
    k = 0;
    while (!csi_hsync && k < 300) begin
      @(negedge csi_pclk);
      k++;
    end
    if (!csi_hsync) fail("hsync_timeout");
  endtask

  task automatic wait_idle(output int at);
    int k;
    k = 0;
    while (busy && k < 300) begin
      @(negedge csi_pclk);
      k++;
    end
    at = cyc;
    if (busy) fail("idle_timeout");
  endtask

  initial begin
    forever begin
      @(posedge csi_pclk);
      cyc++;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a read.
  initial begin
    bit prev_vs, prev_hs;
    int vs_run, hpos;
    prev_vs = 0; prev_hs = 0; vs_run = 0; hpos = 0;
    forever begin
      @(negedge csi_pclk);
      if (!reset_n) begin
        prev_vs = 0; prev_hs = 0; vs_run = 0; hpos = 0;
      end else begin
        if (frame_start) begin
          fs_cyc.push_back(cyc);
          rd_cnt = 0;
        end
        if (csi_vsync) begin
          vs_run++;
        end else if (prev_vs) begin
          vs_len_q.push_back(vs_run);
          vs_fall_q.push_back(cyc);
          vs_run = 0;
        end
        if (csi_hsync && !prev_hs) hs_rise_q.push_back(cyc);
        if (csi_hsync) begin
          if (mon_on) begin
            if (exp_bytes.size() == 0) fail("byte_unexpected");
            else check("byte", 32'(csi_data), 32'(exp_bytes.pop_front()));
          end
          if ((hpos % 2) == 0 && rd_cyc.size() > 0)
            check("rd_lead", 32'(cyc - rd_cyc.pop_front()), 32'd2);
          hpos++;
        end else begin
          hpos = 0;
          if (mon_on) check("blank_data", 32'(csi_data), 32'd0);
        end
        if (rd_en) begin
          rd_cnt++;
          if (mon_on) begin
            if (exp_addr.size() == 0) fail("rd_en_unexpected");
            else check("rdaddr", 32'(rdaddr), 32'(exp_addr.pop_front()));
            rd_cyc.push_back(cyc);
          end
        end
        prev_vs = csi_vsync;
        prev_hs = csi_hsync;
      end
    end
  end

  initial begin
    int t_en, t_idle;
    #23;
    check("rst_vsync", 32'(csi_vsync), 0);
    check("rst_hsync", 32'(csi_hsync), 0);
    check("rst_data", 32'(csi_data), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rdaddr", 32'(rdaddr), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_busy", 32'(busy), 0);

    // Colour bars, two back-to-back frames
    @(negedge csi_pclk);
    reset_n = 1'b1;
    pattern_sel = 1'b1;
    push_pattern_frame();
    push_pattern_frame();
    @(negedge csi_pclk);
    t_en = cyc;
    enable = 1'b1;
    wait_fs(1, 10);
    if (fs_cyc.size() >= 1) check("fs_latency", 32'(fs_cyc[0]), 32'(t_en + 1));
    wait_fs(2, 200);
    if (fs_cyc.size() >= 2) check("fs_period_1", 32'(fs_cyc[1] - fs_cyc[0]), FRAME);
    if (vs_len_q.size() >= 1) check("vsync_len", 32'(vs_len_q[0]), 3);
    else fail("vsync_len_missing");
    if (hs_rise_q.size() >= 1 && vs_fall_q.size() >= 1)
      check("vsync_to_hsync", 32'(hs_rise_q[0] - vs_fall_q[0]), 20);
    else fail("vsync_to_hsync_missing");

    // Frame-buffer frame; enable dropped during its first active line
    pattern_sel = 1'b0;
    push_fb_frame();
    wait_fs(3, 200);
    if (fs_cyc.size() >= 3) check("fs_period_2", 32'(fs_cyc[2] - fs_cyc[1]), FRAME);
    wait_hsync();
    @(negedge csi_pclk);
    enable = 1'b0;
    wait_idle(t_idle);
    if (fs_cyc.size() >= 3) check("frame_complete", 32'(t_idle), 32'(fs_cyc[2] + FRAME));
    check("rd_count", 32'(rd_cnt), 16);
    repeat (150) @(negedge csi_pclk);
    check("no_restart", 32'(fs_cyc.size()), 3);
    check("idle_busy", 32'(busy), 0);
    check("bytes_drained", 32'(exp_bytes.size()), 0);
    check("addr_drained", 32'(exp_addr.size()), 0);

    // Reset mid active line
    mon_on = 1'b0;
    enable = 1'b1;
    wait_fs(4, 10);
    wait_hsync();
    repeat (5) @(negedge csi_pclk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_hsync", 32'(csi_hsync), 0);
    check("arst_data", 32'(csi_data), 0);
    check("arst_rd_en", 32'(rd_en), 0);
    check("arst_rdaddr", 32'(rdaddr), 0);
    check("arst_busy", 32'(busy), 0);
    @(negedge csi_pclk);
    rd_cyc.delete();
    exp_bytes.delete();
    exp_addr.delete();
    push_fb_frame();
    mon_on = 1'b1;
    t_en = cyc;
    reset_n = 1'b1;
    wait_fs(5, 10);
    if (fs_cyc.size() >= 5) check("fs_after_reset", 32'(fs_cyc[4]), 32'(t_en + 1));
    wait_hsync();
    @(negedge csi_pclk);
    enable = 1'b0;
    wait_idle(t_idle);
    if (fs_cyc.size() >= 5) check("frame_complete_2", 32'(t_idle), 32'(fs_cyc[4] + FRAME));
    check("rd_count_2", 32'(rd_cnt), 16);
    check("bytes_drained_2", 32'(exp_bytes.size()), 0);
    check("addr_drained_2", 32'(exp_addr.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
